// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C byte read/write controller between two requesters,
// with a post-transaction gap (EEPROM write time) and a per-transaction timeout watchdog.
module i2c_req_arbiter #(
    parameter int GAP_CYCLES     = 200_000,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int CNT_W          = 20
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,

    input  logic        req0_valid,
    input  logic        req0_rw,
    input  logic [15:0] req0_addr,
    input  logic [7:0]  req0_wdata,
    output logic        req0_ready,
    output logic        req0_done,

    input  logic        req1_valid,
    input  logic        req1_rw,
    input  logic [15:0] req1_addr,
    input  logic [7:0]  req1_wdata,
    output logic        req1_ready,
    output logic        req1_done,

    output logic        req_err,
    output logic [7:0]  req_rdata,

    output logic        wr_en,
    output logic        rd_en,
    output logic        i2c_start,
    output logic [15:0] byte_addr,
    output logic [7:0]  wr_data,
    input  logic        i2c_end,
    input  logic [7:0]  rd_data,

    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic             owner;       // 0 = req0, 1 = req1
    logic             last_grant;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] to_cnt;

    // Winner for this cycle: sole requester, or on a tie the one not granted last time.
    logic        win;
    logic        win_rw;
    logic [15:0] win_addr;
    logic [7:0]  win_wdata;

    always_comb begin
        win = 1'b0;
        if (req0_valid && req1_valid)
            win = ~last_grant;
        else if (req1_valid)
            win = 1'b1;
        win_rw    = win ? req1_rw    : req0_rw;
        win_addr  = win ? req1_addr  : req0_addr;
        win_wdata = win ? req1_wdata : req0_wdata;
    end

    // NOTE: every register, counters included, takes an explicit async reset value so a
    // mid-transaction reset drops wr_en/rd_en at once and never leaves a stale done pulse.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            gap_cnt    <= '0;
            to_cnt     <= '0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req_err    <= 1'b0;
            req_rdata  <= 8'h00;
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            i2c_start  <= 1'b0;
            byte_addr  <= 16'h0000;
            wr_data    <= 8'h00;
            busy       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; the defaults below make every
            // pulse output exactly one cycle wide unless a branch re-asserts it.
            i2c_start  <= 1'b0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req_err    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (req0_valid || req1_valid) begin
                        owner      <= win;
                        last_grant <= win;
                        byte_addr  <= win_addr;
                        wr_data    <= win_wdata;
                        wr_en      <= ~win_rw;
                        rd_en      <= win_rw;
                        i2c_start  <= 1'b1;
                        req0_ready <= ~win;
                        req1_ready <= win;
                        to_cnt     <= '0;
                        busy       <= 1'b1;
                        state      <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    // Normal completion takes precedence over a coincident timeout.
                    if (i2c_end || (to_cnt == TO_LAST)) begin
                        if (i2c_end && rd_en)
                            req_rdata <= rd_data;
                        req_err   <= ~i2c_end;
                        req0_done <= ~owner;
                        req1_done <= owner;
                        wr_en     <= 1'b0;
                        rd_en     <= 1'b0;
                        gap_cnt   <= '0;
                        state     <= ST_GAP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    wr_en <= 1'b0;
                    rd_en <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter (GAP_CYCLES=8, TIMEOUT_CYCLES=64) with hand-computed expectations.
module tb_i2c_req_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_rw = 1'b0, req1_rw = 1'b0;
    logic [15:0] req0_addr = 16'h0, req1_addr = 16'h0;
    logic [7:0]  req0_wdata = 8'h0, req1_wdata = 8'h0;
    logic        req0_ready, req1_ready, req0_done, req1_done;
    logic        req_err;
    logic [7:0]  req_rdata;
    logic        wr_en, rd_en, i2c_start;
    logic [15:0] byte_addr;
    logic [7:0]  wr_data;
    logic        i2c_end = 1'b0;
    logic [7:0]  rd_data = 8'h0;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    i2c_req_arbiter #(.GAP_CYCLES(8), .TIMEOUT_CYCLES(64), .CNT_W(20)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .req0_done(req0_done),
        .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .req1_done(req1_done),
        .req_err(req_err), .req_rdata(req_rdata),
        .wr_en(wr_en), .rd_en(rd_en), .i2c_start(i2c_start),
        .byte_addr(byte_addr), .wr_data(wr_data),
        .i2c_end(i2c_end), .rd_data(rd_data), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_start(output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i2c_start) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (req0_done || req1_done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic end_txn(input logic [7:0] rd);
        i2c_end = 1'b1;
        rd_data = rd;
        tick();
        i2c_end = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40 && busy; i++) tick();
        check(tag, 32'(busy), 32'h0);
    endtask

    int n;

    initial begin
        // Reset values
        tick();
        tick();
        check("rst_busy",   32'(busy), 32'h0);
        check("rst_wr_rd",  32'({wr_en, rd_en, i2c_start}), 32'h0);
        check("rst_pulses", 32'({req0_ready, req1_ready, req0_done, req1_done, req_err}), 32'h0);
        check("rst_addr",   32'(byte_addr), 32'h0);
        check("rst_wdata",  32'(wr_data), 32'h0);
        check("rst_rdata",  32'(req_rdata), 32'h0);
        sys_rst_n = 1'b1;
        tick();

        // Single write from req0
        req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 16'h005A; req0_wdata = 8'h01;
        wait_start(n);
        check("wr_latency", 32'(n), 32'd1);
        check("wr_ready",   32'({req0_ready, req1_ready}), 32'b10);
        check("wr_en",      32'({wr_en, rd_en}), 32'b10);
        check("wr_addr",    32'(byte_addr), 32'h005A);
        check("wr_data",    32'(wr_data), 32'h01);
        check("wr_busy",    32'(busy), 32'h1);
        req0_valid = 1'b0;
        tick();
        check("wr_start_pulse", 32'({i2c_start, req0_ready}), 32'h0);
        check("wr_hold",    32'({wr_en, byte_addr}), 32'h1005A);
        repeat (18) tick();
        end_txn(8'hEE);
        check("wr_done",    32'({req0_done, req1_done, req_err}), 32'b100);
        check("wr_en_clr",  32'({wr_en, rd_en}), 32'h0);
        check("wr_rdata_kept", 32'(req_rdata), 32'h00);
        // Request immediately after done: grant must wait GAP_CYCLES+1 cycles
        req0_valid = 1'b1; req0_addr = 16'h0077; req0_wdata = 8'h02;
        wait_start(n);
        check("gap_latency", 32'(n), 32'd9);
        check("gap_regrant", 32'({req0_ready, byte_addr}), 32'h10077);
        req0_valid = 1'b0;
        repeat (3) tick();
        end_txn(8'h00);
        wait_idle("idle_after_wr");

        // Single read from req1
        req1_valid = 1'b1; req1_rw = 1'b1; req1_addr = 16'h0010; req1_wdata = 8'h99;
        wait_start(n);
        check("rd_latency", 32'(n), 32'd1);
        check("rd_ready",   32'({req0_ready, req1_ready}), 32'b01);
        check("rd_en",      32'({wr_en, rd_en}), 32'b01);
        check("rd_addr",    32'(byte_addr), 32'h0010);
        req1_valid = 1'b0;
        repeat (5) tick();
        check("rd_en_hold", 32'({wr_en, rd_en}), 32'b01);
        end_txn(8'hA5);
        check("rd_done",    32'({req0_done, req1_done, req_err}), 32'b010);
        check("rd_rdata",   32'(req_rdata), 32'hA5);
        check("rd_en_clr",  32'(rd_en), 32'h0);
        tick();
        check("rd_done_pulse", 32'(req1_done), 32'h0);
        wait_idle("idle_after_rd");

        // Round-robin with both requesters valid continuously (writes)
        req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 16'h0100; req0_wdata = 8'h11;
        req1_valid = 1'b1; req1_rw = 1'b0; req1_addr = 16'h0200; req1_wdata = 8'h22;
        for (int i = 0; i < 4; i++) begin
            logic exp_owner;
            exp_owner = logic'(i % 2);
            wait_start(n);
            check($sformatf("rr%0d_latency", i), 32'(n), (i == 0) ? 32'd1 : 32'd9);
            check($sformatf("rr%0d_ready", i), 32'({req0_ready, req1_ready}),
                  exp_owner ? 32'b01 : 32'b10);
            check($sformatf("rr%0d_addr", i), 32'(byte_addr), exp_owner ? 32'h0200 : 32'h0100);
            check($sformatf("rr%0d_wdata", i), 32'(wr_data), exp_owner ? 32'h22 : 32'h11);
            if (i == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            repeat (3) tick();
            check($sformatf("rr%0d_no_ready", i), 32'({req0_ready, req1_ready}), 32'h0);
            end_txn(8'h3C);
            check($sformatf("rr%0d_done", i), 32'({req0_done, req1_done}),
                  exp_owner ? 32'b01 : 32'b10);
            check($sformatf("rr%0d_rdata", i), 32'(req_rdata), 32'hA5);
        end
        wait_idle("idle_after_rr");

        // Timeout: i2c_end never arrives
        req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 16'h0400; req0_wdata = 8'h33;
        wait_start(n);
        check("to_latency", 32'(n), 32'd1);
        req0_valid = 1'b0;
        wait_done(n);
        check("to_cycles",  32'(n), 32'd64);
        check("to_done",    32'({req0_done, req1_done, req_err}), 32'b101);
        check("to_en_clr",  32'({wr_en, rd_en}), 32'h0);
        check("to_rdata",   32'(req_rdata), 32'hA5);
        // Spurious i2c_end during GAP
        i2c_end = 1'b1; rd_data = 8'h55;
        tick();
        i2c_end = 1'b0;
        check("to_err_clr", 32'(req_err), 32'h0);
        check("gap_spurious", 32'({req0_done, req1_done}), 32'h0);
        check("gap_rdata",  32'(req_rdata), 32'hA5);
        wait_idle("idle_after_to");

        // i2c_end on the same cycle as the timeout
        req1_valid = 1'b1; req1_rw = 1'b1; req1_addr = 16'h0500;
        wait_start(n);
        check("tie_latency", 32'(n), 32'd1);
        req1_valid = 1'b0;
        repeat (63) tick();
        check("tie_no_early", 32'(req1_done), 32'h0);
        end_txn(8'hBB);
        check("tie_done",   32'({req0_done, req1_done, req_err}), 32'b010);
        check("tie_rdata",  32'(req_rdata), 32'hBB);
        wait_idle("idle_after_tie");

        // Spurious i2c_end in IDLE
        i2c_end = 1'b1;
        tick();
        i2c_end = 1'b0;
        check("idle_spurious", 32'({req0_done, req1_done, busy, i2c_start}), 32'h0);

        // Reset at cycle 10 of a read, with req0 pending
        req1_valid = 1'b1; req1_rw = 1'b1; req1_addr = 16'h0600;
        wait_start(n);
        check("rst_txn_latency", 32'(n), 32'd1);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 16'h0300; req0_wdata = 8'h44;
        repeat (9) tick();
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_en",    32'({wr_en, rd_en, busy}), 32'h0);
        check("mid_rst_addr",  32'(byte_addr), 32'h0);
        check("mid_rst_rdata", 32'(req_rdata), 32'h0);
        tick();
        check("mid_rst_pulses", 32'({req0_done, req1_done, req0_ready, req1_ready, req_err, i2c_start}), 32'h0);
        sys_rst_n = 1'b1;
        wait_start(n);
        check("post_rst_latency", 32'(n), 32'd1);
        check("post_rst_ready", 32'({req0_ready, req1_ready}), 32'b10);
        check("post_rst_txn",  32'({wr_en, rd_en, byte_addr, wr_data}), {2'b10, 16'h0300, 8'h44});
        req0_valid = 1'b0;
        end_txn(8'h00);
        check("post_rst_done", 32'({req0_done, req_err}), 32'b10);
        wait_idle("idle_final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
